// File: rtl/oflow_score_calc_pkg.sv
// Shared types and default sizing for the optical-flow score-calculation scheduler.
package oflow_score_calc_pkg;

    localparam int DEF_MAX_OBJ  = 32;
    localparam int DEF_MAX_PREV = 64;
    localparam int DEF_CHUNK    = 8;
    localparam int DEF_OBJ_W    = $clog2(DEF_MAX_OBJ + 1);
    localparam int DEF_PREV_W   = $clog2(DEF_MAX_PREV + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SIM,
        S_WAIT_SIM,
        S_MIN,
        S_WAIT_MIN,
        S_ADV,
        S_FIN
    } sched_state_t;

endpackage

// File: rtl/oflow_score_calc_scheduler_if.sv
// Controller / similarity_metric / calc_min handshake bundle around the scheduler.
interface oflow_score_calc_scheduler_if
    import oflow_score_calc_pkg::*;
#(
    parameter int OBJ_W  = DEF_OBJ_W,
    parameter int PREV_W = DEF_PREV_W,
    parameter int CHUNK  = DEF_CHUNK
);
    logic              start_frame;
    logic [OBJ_W-1:0]  num_cur_obj;
    logic [PREV_W-1:0] num_prev_obj;
    logic              busy;
    logic              start_similarity_metric;
    logic              done_similarity_metric;
    logic              start_calc_min;
    logic              done_calc_min;
    logic [OBJ_W-1:0]  cur_obj_idx;
    logic [PREV_W-1:0] prev_base_addr;
    logic [CHUNK-1:0]  valid_mask;
    logic              first_chunk;
    logic              last_chunk;
    logic              done_obj;
    logic              done_frame;

    modport master (
        input  start_frame, num_cur_obj, num_prev_obj,
               done_similarity_metric, done_calc_min,
        output busy, start_similarity_metric, start_calc_min,
               cur_obj_idx, prev_base_addr, valid_mask,
               first_chunk, last_chunk, done_obj, done_frame
    );

    modport slave (
        output start_frame, num_cur_obj, num_prev_obj,
               done_similarity_metric, done_calc_min,
        input  busy, start_similarity_metric, start_calc_min,
               cur_obj_idx, prev_base_addr, valid_mask,
               first_chunk, last_chunk, done_obj, done_frame
    );
endinterface

// File: rtl/oflow_score_calc_chunk_cnt.sv
// Candidate-chunk base address plus first/last flags and valid mask for the active chunk.
module oflow_score_calc_chunk_cnt #(
    parameter int CHUNK  = 8,
    parameter int PREV_W = 7
) (
    input  logic              clk,
    input  logic              reset_N,
    input  logic              clr,
    input  logic              inc,
    input  logic              en,
    input  logic [PREV_W-1:0] n_prev,
    output logic [PREV_W-1:0] prev_base_addr,
    output logic              first_chunk,
    output logic              last_chunk,
    output logic [CHUNK-1:0]  valid_mask
);
    logic [PREV_W-1:0] base;
    logic [PREV_W:0]   end_addr;
    logic [PREV_W-1:0] remain;
    logic              last_raw;
    logic [CHUNK-1:0]  mask_raw;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            base <= '0;
        end else if (clr) begin
            base <= '0;
        end else if (inc) begin
            base <= base + PREV_W'(CHUNK);
        end
    end

    // Extra bit on end_addr keeps base+CHUNK from wrapping near MAX_PREV.
    assign end_addr = {1'b0, base} + (PREV_W+1)'(CHUNK);
    assign last_raw = (end_addr >= {1'b0, n_prev});
    assign remain   = n_prev - base;

    always_comb begin
        mask_raw = '0;
        for (int i = 0; i < CHUNK; i++) begin
            mask_raw[i] = !last_raw || (PREV_W'(i) < remain);
        end
    end

    // Flags and mask are only meaningful while a chunk is being scored.
    assign prev_base_addr = base;
    assign first_chunk    = en && (base == '0);
    assign last_chunk     = en && last_raw;
    assign valid_mask     = en ? mask_raw : '0;
endmodule

// File: rtl/oflow_score_calc_scheduler.sv
// Per-frame sequencer: sweeps candidate chunks per object, pulsing similarity_metric then calc_min.
module oflow_score_calc_scheduler
    import oflow_score_calc_pkg::*;
#(
    parameter int MAX_OBJ  = DEF_MAX_OBJ,
    parameter int MAX_PREV = DEF_MAX_PREV,
    parameter int CHUNK    = DEF_CHUNK,
    parameter int OBJ_W    = $clog2(MAX_OBJ + 1),
    parameter int PREV_W   = $clog2(MAX_PREV + 1)
) (
    input  logic                          clk,
    input  logic                          reset_N,
    oflow_score_calc_scheduler_if.master  bus
);
    sched_state_t      state;
    logic [OBJ_W-1:0]  n_cur;
    logic [OBJ_W-1:0]  obj_idx;
    logic [PREV_W-1:0] n_prev;
    logic              chunk_clr;
    logic              chunk_inc;
    logic              chunk_en;
    logic              last_chunk;

    function automatic logic [OBJ_W-1:0] sat_obj(input logic [OBJ_W-1:0] n);
        return (n > OBJ_W'(MAX_OBJ)) ? OBJ_W'(MAX_OBJ) : n;
    endfunction

    function automatic logic [PREV_W-1:0] sat_prev(input logic [PREV_W-1:0] n);
        return (n > PREV_W'(MAX_PREV)) ? PREV_W'(MAX_PREV) : n;
    endfunction

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state   <= S_IDLE;
            n_cur   <= '0;
            n_prev  <= '0;
            obj_idx <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start_frame) begin
                    n_cur   <= sat_obj(bus.num_cur_obj);
                    n_prev  <= sat_prev(bus.num_prev_obj);
                    obj_idx <= '0;
                    state   <= (bus.num_cur_obj == '0 || bus.num_prev_obj == '0) ? S_FIN : S_SIM;
                end
                S_SIM:      state <= S_WAIT_SIM;
                S_WAIT_SIM: if (bus.done_similarity_metric) state <= S_MIN;
                S_MIN:      state <= S_WAIT_MIN;
                S_WAIT_MIN: if (bus.done_calc_min) state <= last_chunk ? S_ADV : S_SIM;
                S_ADV: begin
                    if (obj_idx == n_cur - OBJ_W'(1)) begin
                        state <= S_FIN;
                    end else begin
                        obj_idx <= obj_idx + OBJ_W'(1);
                        state   <= S_SIM;
                    end
                end
                S_FIN: begin
                    obj_idx <= '0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Base clears at ADV's closing edge, so done_obj still sees the finished chunk.
    assign chunk_clr = (state == S_IDLE && bus.start_frame) || (state == S_ADV) || (state == S_FIN);
    assign chunk_inc = (state == S_WAIT_MIN) && bus.done_calc_min && !last_chunk;
    assign chunk_en  = (state == S_SIM) || (state == S_WAIT_SIM) || (state == S_MIN) ||
                       (state == S_WAIT_MIN) || (state == S_ADV);

    oflow_score_calc_chunk_cnt #(
        .CHUNK  (CHUNK),
        .PREV_W (PREV_W)
    ) u_chunk_cnt (
        .clk            (clk),
        .reset_N        (reset_N),
        .clr            (chunk_clr),
        .inc            (chunk_inc),
        .en             (chunk_en),
        .n_prev         (n_prev),
        .prev_base_addr (bus.prev_base_addr),
        .first_chunk    (bus.first_chunk),
        .last_chunk     (last_chunk),
        .valid_mask     (bus.valid_mask)
    );

    assign bus.last_chunk              = last_chunk;
    assign bus.cur_obj_idx             = obj_idx;
    assign bus.busy                    = (state != S_IDLE);
    assign bus.start_similarity_metric = (state == S_SIM);
    assign bus.start_calc_min          = (state == S_MIN);
    assign bus.done_obj                = (state == S_ADV);
    assign bus.done_frame              = (state == S_FIN);
endmodule

// File: tb/tb_oflow_score_calc_scheduler.sv
// Directed plus randomized frames for the score-calc scheduler against a chunk-list reference model.
module tb_oflow_score_calc_scheduler;
    import oflow_score_calc_pkg::*;

    localparam int OBJ_W  = DEF_OBJ_W;
    localparam int PREV_W = DEF_PREV_W;
    localparam int CHUNK  = DEF_CHUNK;
    localparam int ENT_W  = OBJ_W + PREV_W + CHUNK + 2;
    localparam int SNP_W  = OBJ_W + PREV_W + CHUNK;

    typedef logic [ENT_W-1:0] ent_t;

    logic clk = 1'b0;
    logic reset_N = 1'b0;
    always #5 clk = ~clk;

    oflow_score_calc_scheduler_if #(.OBJ_W(OBJ_W), .PREV_W(PREV_W), .CHUNK(CHUNK)) bus ();

    oflow_score_calc_scheduler #(
        .MAX_OBJ  (DEF_MAX_OBJ),
        .MAX_PREV (DEF_MAX_PREV),
        .CHUNK    (CHUNK)
    ) dut (
        .clk     (clk),
        .reset_N (reset_N),
        .bus     (bus)
    );

    // Completion responder: each start answered after a programmable delay.
    logic resp_sim = 1'b0, resp_min = 1'b0, inj_sim = 1'b0, inj_min = 1'b0;
    int   sim_dly = 1, min_dly = 1, sp = 0, mp = 0;
    bit   rand_dly = 1'b0;

    assign bus.done_similarity_metric = resp_sim | inj_sim;
    assign bus.done_calc_min          = resp_min | inj_min;

    always @(posedge clk) begin
        #1;
        resp_sim = 1'b0;
        resp_min = 1'b0;
        if (!reset_N) begin
            sp = 0;
            mp = 0;
        end else begin
            if (sp > 0) begin sp--; if (sp == 0) resp_sim = 1'b1; end
            if (mp > 0) begin mp--; if (mp == 0) resp_min = 1'b1; end
            if (bus.start_similarity_metric) sp = rand_dly ? int'($urandom_range(1, 4)) : sim_dly;
            if (bus.start_calc_min)          mp = rand_dly ? int'($urandom_range(1, 4)) : min_dly;
        end
    end

    // Monitor: records chunk starts, object completions and timing anomalies.
    int   cyc = 0, frames = 0, mins = 0, stab_err = 0, gap_err = 0, dsim_cyc = -100, frame_cyc = 0;
    ent_t sim_q[$];
    int   dobj_q[$];
    logic in_chunk = 1'b0;
    logic [SNP_W-1:0] snap = '0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_N) begin
            in_chunk = 1'b0;
        end else begin
            if (bus.start_similarity_metric) begin
                sim_q.push_back({bus.cur_obj_idx, bus.prev_base_addr, bus.valid_mask,
                                 bus.first_chunk, bus.last_chunk});
                snap = {bus.cur_obj_idx, bus.prev_base_addr, bus.valid_mask};
                in_chunk = 1'b1;
            end
            if (in_chunk && ({bus.cur_obj_idx, bus.prev_base_addr, bus.valid_mask} !== snap)) stab_err++;
            if (in_chunk && resp_min) in_chunk = 1'b0;
            if (resp_sim) dsim_cyc = cyc;
            if (bus.start_calc_min) begin
                mins++;
                if (cyc - dsim_cyc != 1) gap_err++;
            end
            if (bus.done_obj) dobj_q.push_back(int'(bus.cur_obj_idx));
            if (bus.done_frame) begin frames++; frame_cyc = cyc; end
        end
    end

    int   total = 0, bad = 0;
    ent_t exp_q[$];
    int   exp_dobj[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: every object sweeps candidates 0..n-1 in CHUNK-wide slices.
    function automatic void build_exp(input int nc, input int np);
        int nce, npe, rem;
        logic [CHUNK-1:0] m;
        exp_q.delete();
        exp_dobj.delete();
        nce = (nc > DEF_MAX_OBJ) ? DEF_MAX_OBJ : nc;
        npe = (np > DEF_MAX_PREV) ? DEF_MAX_PREV : np;
        if (nce == 0 || npe == 0) return;
        for (int o = 0; o < nce; o++) begin
            for (int b = 0; b < npe; b += CHUNK) begin
                rem = npe - b;
                m = '0;
                for (int k = 0; k < CHUNK; k++) m[k] = (k < rem);
                exp_q.push_back({OBJ_W'(o), PREV_W'(b), m, (b == 0), (b + CHUNK >= npe)});
            end
            exp_dobj.push_back(o);
        end
    endfunction

    task automatic clear_mon();
        sim_q.delete();
        dobj_q.delete();
        mins = 0;
        stab_err = 0;
        gap_err = 0;
    endtask

    task automatic kick(input int nc, input int np);
        @(negedge clk); #1;
        bus.num_cur_obj  = OBJ_W'(nc);
        bus.num_prev_obj = PREV_W'(np);
        bus.start_frame  = 1'b1;
        @(negedge clk); #1;
        bus.start_frame  = 1'b0;
    endtask

    task automatic wait_frame(input int f0, input string tag);
        for (int i = 0; i < 20000 && frames == f0; i++) begin
            @(negedge clk); #1;
        end
        chk({tag, "_frames"}, frames - f0, 1);
        @(negedge clk); #1;
        chk({tag, "_idle"}, bus.busy, 1'b0);
    endtask

    task automatic check_frame(input string tag);
        int n;
        chk({tag, "_nsim"}, sim_q.size(), exp_q.size());
        n = (sim_q.size() < exp_q.size()) ? sim_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_chunk%0d", tag, i), sim_q[i], exp_q[i]);
        chk({tag, "_nmin"}, mins, exp_q.size());
        chk({tag, "_ndobj"}, dobj_q.size(), exp_dobj.size());
        n = (dobj_q.size() < exp_dobj.size()) ? dobj_q.size() : exp_dobj.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_dobj%0d", tag, i), dobj_q[i], exp_dobj[i]);
        chk({tag, "_stable"}, stab_err, 0);
        chk({tag, "_mingap"}, gap_err, 0);
    endtask

    task automatic run_frame(input int nc, input int np, input string tag);
        int f0;
        clear_mon();
        build_exp(nc, np);
        f0 = frames;
        kick(nc, np);
        chk({tag, "_busy"}, bus.busy, 1'b1);
        wait_frame(f0, tag);
        check_frame(tag);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {bus.busy, bus.start_similarity_metric, bus.start_calc_min, bus.cur_obj_idx,
                  bus.prev_base_addr, bus.valid_mask, bus.first_chunk, bus.last_chunk,
                  bus.done_obj, bus.done_frame}, '0);
    endtask

    initial begin
        int f0, st_cyc;
        bus.start_frame  = 1'b0;
        bus.num_cur_obj  = '0;
        bus.num_prev_obj = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset_outputs");
        reset_N = 1'b1;
        @(negedge clk); #1;
        chk_all_zero("idle_outputs");

        run_frame(2, 20, "f2x20");
        run_frame(1, 16, "f1x16");
        run_frame(3, 8, "f3x8");

        // Empty frame goes straight to FIN
        clear_mon();
        build_exp(0, 5);
        f0 = frames;
        @(negedge clk); #1;
        bus.num_cur_obj = OBJ_W'(0); bus.num_prev_obj = PREV_W'(5); bus.start_frame = 1'b1;
        st_cyc = cyc;
        @(negedge clk); #1;
        bus.start_frame = 1'b0;
        wait_frame(f0, "zero");
        chk("zero_lat_ok", (frame_cyc - st_cyc >= 1) && (frame_cyc - st_cyc <= 2), 1'b1);
        check_frame("zero");

        // Spurious done_calc_min and start_frame while waiting on similarity
        sim_dly = 5;
        clear_mon();
        build_exp(3, 12);
        f0 = frames;
        kick(3, 12);
        @(negedge clk); #1;
        inj_min = 1'b1;
        bus.num_cur_obj = OBJ_W'(1); bus.num_prev_obj = PREV_W'(3); bus.start_frame = 1'b1;
        @(negedge clk); #1;
        inj_min = 1'b0;
        bus.start_frame = 1'b0;
        chk("spur_nmin_hold", mins, 0);
        wait_frame(f0, "spur");
        check_frame("spur");

        // Long similarity latency
        sim_dly = 50;
        run_frame(1, 10, "slow");
        sim_dly = 1;

        // Saturation of oversize counts
        run_frame(40, 100, "sat");

        // Randomized counts and response delays
        rand_dly = 1'b1;
        for (int r = 0; r < 6; r++) begin
            run_frame(int'($urandom_range(0, 35)), int'($urandom_range(0, 70)), $sformatf("rnd%0d", r));
        end
        rand_dly = 1'b0;

        // Reset during WAIT_MIN of object 1
        min_dly = 6;
        clear_mon();
        f0 = frames;
        kick(2, 20);
        for (int i = 0; i < 2000 && !(bus.start_calc_min && bus.cur_obj_idx == OBJ_W'(1)); i++) begin
            @(negedge clk); #1;
        end
        chk("rst_reached_min1", {bus.start_calc_min, bus.cur_obj_idx}, {1'b1, OBJ_W'(1)});
        @(negedge clk); #1;
        reset_N = 1'b0;
        #1;
        chk_all_zero("midrst_outputs");
        repeat (3) @(negedge clk);
        #1;
        chk("midrst_no_frame", frames - f0, 0);
        reset_N = 1'b1;
        min_dly = 1;
        run_frame(2, 20, "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
